// File: rtl/mul_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
package mul_pkg;

    localparam int WIDTH = 32;          // operand width; only 32 is supported
    localparam int ITERS = WIDTH / 2;   // one radix-4 digit per iteration
    localparam int ADD_W = WIDTH + 2;   // room for +/-2M on top of the partial product
    localparam int CNT_W = 4;           // enough to count ITERS iterations

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } booth_t;

    // Radix-4 Booth digit from {q[i+1], q[i], q[i-1]}.
    function automatic booth_t booth_decode(input logic [2:0] bits);
        booth_t d;
        case (bits)
            3'b001, 3'b010: d = P1;
            3'b011:         d = P2;
            3'b100:         d = M2;
            3'b101, 3'b110: d = M1;
            default:        d = ZERO;   // 000 and 111
        endcase
        return d;
    endfunction

endpackage

// File: rtl/adder_34.sv
// Plain 34-bit ripple-carry adder: sum = a + b + cin.
module adder_34
    import mul_pkg::*;
(
    input  logic [ADD_W-1:0] i_a,
    input  logic [ADD_W-1:0] i_b,
    input  logic             i_cin,
    output logic [ADD_W-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    // Bit-serial carry chain; signed overflow flags a sign flip with like-signed inputs.
    always_comb begin
        logic w_carry;
        w_carry = i_cin;
        o_sum   = '0;
        for (int i = 0; i < ADD_W; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
        o_ovf  = (i_a[ADD_W-1] == i_b[ADD_W-1]) && (o_sum[ADD_W-1] != i_a[ADD_W-1]);
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed 32x32 multiplier, radix-4 Booth, one digit per clock.
// start is taken only while ready=1 (IDLE or DONE); done is a one-cycle
// pulse coinciding with DONE, during which a new start is accepted with no bubble.
module booth_mul_seq
    import mul_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output state_t             o_dbg_state
);

    state_t             r_state;
    state_t             w_next_state;
    logic [ADD_W-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_qm1;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_mcand;

    booth_t             w_digit;
    logic [ADD_W-1:0]   w_addend;
    logic               w_neg;
    logic [ADD_W-1:0]   w_b;
    logic [ADD_W-1:0]   w_sum;
    logic               w_cout;
    logic               w_ovf;
    logic               w_load;
    logic               w_last;

    // The sum provably stays in range, so carry-out and overflow are not consumed.
    wire w_unused = w_cout ^ w_ovf;

    assign w_load = start & ready;
    assign w_last = (r_count == CNT_W'(ITERS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = BUSY;
            BUSY:    if (w_last) w_next_state = DONE;
            DONE:    w_next_state = start ? BUSY : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        ready       = (r_state == IDLE) || (r_state == DONE);
        busy        = (r_state == BUSY);
        done        = (r_state == DONE);
        o_dbg_state = r_state;
    end

    // Booth recode and addend select; negative digits add ~X with cin=1.
    always_comb begin
        w_digit  = booth_decode({r_lo[1], r_lo[0], r_qm1});
        w_addend = '0;
        w_neg    = 1'b0;
        case (w_digit)
            P1: w_addend = {{2{r_mcand[WIDTH-1]}}, r_mcand};
            P2: w_addend = {r_mcand[WIDTH-1], r_mcand, 1'b0};
            M1: begin
                w_addend = {{2{r_mcand[WIDTH-1]}}, r_mcand};
                w_neg    = 1'b1;
            end
            M2: begin
                w_addend = {r_mcand[WIDTH-1], r_mcand, 1'b0};
                w_neg    = 1'b1;
            end
            default: w_addend = '0;
        endcase
        w_b = w_neg ? ~w_addend : w_addend;
    end

    adder_34 u_adder (
        .i_a    (r_hi),
        .i_b    (w_b),
        .i_cin  (w_neg),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_ovf  (w_ovf)
    );

    // Operand load, per-iteration arithmetic shift by 2, and product capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_qm1   <= 1'b0;
            r_count <= '0;
            r_mcand <= '0;
            product <= '0;
        end else if (w_load) begin
            r_hi    <= '0;
            r_lo    <= multiplier;
            r_qm1   <= 1'b0;
            r_count <= '0;
            r_mcand <= multiplicand;
        end else if (r_state == BUSY) begin
            r_hi    <= {w_sum[ADD_W-1], w_sum[ADD_W-1], w_sum[ADD_W-1:2]};
            r_lo    <= {w_sum[1:0], r_lo[WIDTH-1:2]};
            r_qm1   <= r_lo[1];
            r_count <= r_count + 1'b1;
            if (w_last) product <= {w_sum[ADD_W-1:2], w_sum[1:0], r_lo[WIDTH-1:2]};
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq with a short signed-random tail.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [1:0]  dbg_state;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    booth_mul_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .o_dbg_state  (dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Drive start for exactly one edge; returns #1 after the accepting edge.
    task automatic start_op(input logic [31:0] m, input logic [31:0] q);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    // Count edges from the accepting edge to done; expects exactly 16.
    task automatic wait_done(input string tag, input logic [63:0] exp);
        int lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'd16);
        chk({tag, " product"}, product, exp);
    endtask

    task automatic run_mul(input string tag, input logic [31:0] m, input logic [31:0] q,
                           input logic [63:0] exp);
        @(negedge clk);
        start_op(m, q);
        wait_done(tag, exp);
    endtask

    initial begin
        int          lat;
        logic        glitch;
        logic        seen_done;
        logic        b2b;
        logic [31:0] m;
        logic [31:0] q;

        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        chk("rst ready",   64'(ready),     64'd1);
        chk("rst busy",    64'(busy),      64'd0);
        chk("rst done",    64'(done),      64'd0);
        chk("rst product", product,        64'd0);
        chk("rst state",   64'(dbg_state), 64'd0);
        rst_n = 1'b1;

        // Basic operation and output hold.
        @(negedge clk);
        start_op(32'd3, 32'd5);
        chk("3x5 ready drop", 64'(ready), 64'd0);
        chk("3x5 busy rise",  64'(busy),  64'd1);
        wait_done("3x5", 64'h0000_0000_0000_000F);
        repeat (4) @(negedge clk);
        chk("3x5 hold product", product,    64'h0000_0000_0000_000F);
        chk("3x5 idle done",    64'(done),  64'd0);
        chk("3x5 idle ready",   64'(ready), 64'd1);

        // Back-to-back: second start presented during the done cycle.
        @(negedge clk);
        start_op(32'hFFFF_FFF9, 32'd6);
        wait_done("m7x6", 64'hFFFF_FFFF_FFFF_FFD6);
        start_op(32'd6, 32'hFFFF_FFF9);
        wait_done("6xm7 b2b", 64'hFFFF_FFFF_FFFF_FFD6);

        // Extremes.
        run_mul("min x min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_mul("max x min", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
        run_mul("m1 x m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        run_mul("zero x max", 32'd0,        32'h7FFF_FFFF, 64'd0);

        // start while busy must be ignored.
        @(negedge clk);
        start_op(32'd2, 32'd3);
        lat    = 0;
        glitch = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            if (lat == 5) begin
                start        = 1'b1;
                multiplicand = 32'd9;
                multiplier   = 32'd9;
            end else if (lat == 6) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (done !== 1'b1 && busy !== 1'b1) glitch = 1'b1;
        end
        chk("ignore latency", 64'(lat),    64'd16);
        chk("ignore product", product,     64'd6);
        chk("ignore busy",    64'(glitch), 64'd0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        start_op(32'd100, 32'd100);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset product", product,    64'd0);
        chk("areset busy",    64'(busy),  64'd0);
        chk("areset done",    64'(done),  64'd0);
        chk("areset ready",   64'(ready), 64'd1);
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        chk("areset no done", 64'(seen_done), 64'd0);
        rst_n = 1'b1;
        run_mul("after reset", 32'd100, 32'd100, 64'd10000);

        // Signed random pairs against a 64-bit reference, with gaps and restarts.
        b2b = 1'b0;
        for (int i = 0; i < 300; i++) begin
            m = $urandom;
            q = $urandom;
            exp_q.push_back(64'(longint'($signed(m)) * longint'($signed(q))));
            if (!b2b) repeat ($urandom_range(0, 3)) @(negedge clk);
            start_op(m, q);
            wait_done("rnd", exp_q.pop_front());
            b2b = 1'($urandom_range(0, 1));
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
